seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receiving end of the board's multiplexed 4-digit 7-segment display bus.
- Samples digit-select and segment lines, filters transition ghosting and decodes each digit's pattern back to a hex code, blank flag and decimal-point flag.
- Publishes a coherent 4-digit frame.
- Used in self-check / loopback of the display selector, and to read an external controller's display.

Parameters:
- STABLE_CYC, 4, consecutive identical samples required before a digit is captured (min 1).
- TIMEOUT_CYC, 200000, clock cycles without a completed frame before Stale asserts.
- SEG_ACTIVE_LOW, 1, 1 = segment lines active-low (common anode).
- DIG_ACTIVE_LOW, 1, 1 = digit selects active-low.

Ports:
- Clk  input  1  system clock
- Rst  input  1  asynchronous active-high reset
- SEG_D  input  4  digit selects D4..D1 (bit0 = D1)
- SEG  input  7  segments {G,F,E,D,C,B,A}
- SEG_P  input  1  decimal point
- Digits  output  16  hex codes, [3:0] = D1 ... [15:12] = D4
- Blank  output  4  per-digit all-segments-off flag
- DP  output  4  per-digit decimal point
- Err  output  4  per-digit unrecognised pattern flag
- FrameValid  output  1  one-cycle pulse when a new frame is published
- Stale  output  1  no frame within TIMEOUT_CYC

Behaviour:
- Reset (async, Rst=1): Digits=0, Blank=4'hF, DP=0, Err=0, FrameValid=0, Stale=0, FSM=WAIT, run counter=0, seen=0, timeout counter=0.
- Inputs are double-flop synchronised, then normalised to active-high per the polarity parameters. All timing below is counted from the synchronised sample: 2 cycles of input latency.
- Sample valid only when normalised SEG_D is exactly one-hot. Zero or multiple selects are a "gap".
- FSM states:
  - WAIT: on a valid sample, load prev_sel/prev_seg/prev_dp and set run=1 → COUNT (or → HELD if STABLE_CYC=1, capturing immediately).
  - COUNT: sample equals prev → run++. If run reaches STABLE_CYC, capture → HELD. Sample differs and is valid → reload prev, run=1, stay. Gap → WAIT.
  - HELD: sample equals prev → stay, no recapture. Differs and valid → reload, run=1 → COUNT. Gap → WAIT.
- Capture writes the shadow registers for the selected digit and sets seen[digit].
- Decode uses standard hex patterns 0–F (A,b,C,d,E,F as board font):
  - All off → code 0, blank=1, err=0.
  - Pattern not in the table and not blank → code 0, err=1.
  - DP is captured as-is.
- Frame publish: when seen==4'hF after a capture cycle:
  - Copy shadow to Digits/Blank/DP/Err next cycle.
  - Pulse FrameValid for 1 cycle.
  - Clear seen.
  - Clear timeout counter and Stale.
- The same digit captured twice before the frame completes overwrites its shadow (last value wins).
- Outputs hold their last frame between publishes; there is no partial update.
- Timeout counter increments every cycle and saturates at TIMEOUT_CYC. On reaching it, Stale=1. Stale is cleared only by a publish or by reset.
- A capture and a timeout in the same cycle: the publish wins and Stale stays 0.
- Reset mid-frame discards shadow/seen. The first frame after reset needs all 4 digits again.

Optional Feature:
- Macro: SEGDEC_ERRCNT_EN.
- With the macro defined:
  - Adds output ErrCnt (8 bits), reset to 0.
  - Increments once per captured digit with err=1 and once per transition from COUNT into WAIT (ghost gap).
  - Saturates at 255; cleared only by Rst.
- Without the macro: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset → Digits=0, Blank=F, DP=0, Err=0, FrameValid=0, Stale=0, and held while Rst=1 regardless of inputs.
- Scan "1","2","3","4" on D1..D4, 8 cycles each with active-low levels, STABLE_CYC=4 → one FrameValid pulse after D4 capture, Digits=16'h4321, Blank=0, Err=0. Repeated scanning → one pulse per 4 captures.
- Same scan, but each digit's first 2 cycles carry the previous digit's segments (ghosting) → decoded frame still 16'h4321.
- D2 shows pattern 7'b1111111 normalised ("8") with DP=1, D3 all off, D4 shows 7'b0100101 (invalid) → Digits[7:4]=8, DP=4'b0010, Blank=4'b0100, Err=4'b1000. With SEGDEC_ERRCNT_EN, ErrCnt increments by 1.
- Hold SEG_D inactive for TIMEOUT_CYC=50 (override) → Stale=1 at cycle 50 after the last publish. Next complete frame → Stale=0 with FrameValid.
- Assert Rst after D1..D3 captured, release, then scan only D4 → no FrameValid until D1..D3 are rescanned.

Source files
------------

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Receiver for a multiplexed 4-digit 7-segment display bus.
//               Synchronises digit-select/segment lines, filters ghosting
//               during digit transitions, decodes each digit back to a hex
//               code with blank/dp/error flags, and publishes whole frames.
//               Optional macro SEGDEC_ERRCNT_EN adds the ErrCnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE_CYC     = 4,
    parameter int TIMEOUT_CYC    = 200000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  SEG_D,
    input  logic [6:0]  SEG,
    input  logic        SEG_P,
    output logic [15:0] Digits,
    output logic [3:0]  Blank,
    output logic [3:0]  DP,
    output logic [3:0]  Err,
    output logic        FrameValid,
`ifdef SEGDEC_ERRCNT_EN
    output logic [7:0]  ErrCnt,
`endif
    output logic        Stale
);

    localparam int c_RUN_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_RUN_W:0]   c_STABLE  = STABLE_CYC[c_RUN_W:0];
    localparam logic [c_TO_W-1:0]  c_TIMEOUT = TIMEOUT_CYC[c_TO_W-1:0];

    // Raw idle levels, so the synchronisers come out of reset showing a gap
    localparam logic [3:0] c_DIG_IDLE = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] c_SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       c_DP_IDLE  = SEG_ACTIVE_LOW;

    localparam logic [1:0] c_ST_WAIT  = 2'd0;
    localparam logic [1:0] c_ST_COUNT = 2'd1;
    localparam logic [1:0] c_ST_HELD  = 2'd2;

    logic [3:0]         r_dig_s1, r_dig_s2;
    logic [6:0]         r_seg_s1, r_seg_s2;
    logic               r_dp_s1, r_dp_s2;

    logic [1:0]         r_state;
    logic [c_RUN_W-1:0] r_run;
    logic [3:0]         r_prev_sel;
    logic [6:0]         r_prev_seg;
    logic               r_prev_dp;

    logic [15:0]        r_sh_code;
    logic [3:0]         r_sh_blank;
    logic [3:0]         r_sh_dp;
    logic [3:0]         r_sh_err;
    logic [3:0]         r_seen;
    logic [c_TO_W-1:0]  r_to_cnt;

    logic [3:0]         w_sel;
    logic [6:0]         w_seg;
    logic               w_dp;
    logic               w_valid;
    logic               w_same;
    logic [c_RUN_W:0]   w_run_inc;
    logic               w_capture;
    logic               w_publish;
    logic [1:0]         w_idx;
    logic [3:0]         w_code;
    logic               w_blank;
    logic               w_err;
    logic [c_TO_W-1:0]  w_to_next;

    // Two-flop synchronisers on every bus line
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_dig_s1 <= c_DIG_IDLE;
            r_dig_s2 <= c_DIG_IDLE;
            r_seg_s1 <= c_SEG_IDLE;
            r_seg_s2 <= c_SEG_IDLE;
            r_dp_s1  <= c_DP_IDLE;
            r_dp_s2  <= c_DP_IDLE;
        end else begin
            r_dig_s1 <= SEG_D;
            r_dig_s2 <= r_dig_s1;
            r_seg_s1 <= SEG;
            r_seg_s2 <= r_seg_s1;
            r_dp_s1  <= SEG_P;
            r_dp_s2  <= r_dp_s1;
        end
    end

    // Normalise to active-high and qualify the sample
    always_comb begin
        w_sel     = r_dig_s2 ^ {4{DIG_ACTIVE_LOW}};
        w_seg     = r_seg_s2 ^ {7{SEG_ACTIVE_LOW}};
        w_dp      = r_dp_s2 ^ SEG_ACTIVE_LOW;
        w_valid   = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
        w_same    = (w_sel == r_prev_sel) && (w_seg == r_prev_seg) && (w_dp == r_prev_dp);
        w_run_inc = {1'b0, r_run} + 1'b1;
        w_capture = w_valid &&
                    (((r_state == c_ST_WAIT) && (STABLE_CYC <= 1)) ||
                     ((r_state == c_ST_COUNT) && w_same && (w_run_inc >= c_STABLE)));
        w_publish = (r_seen == 4'hF);
        w_to_next = r_to_cnt + 1'b1;
    end

    // One-hot select to digit index
    always_comb begin
        w_idx = 2'd0;
        case (w_sel)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Segment pattern {G,F,E,D,C,B,A} to hex code, blank and error flags
    always_comb begin
        w_code  = 4'h0;
        w_blank = 1'b0;
        w_err   = 1'b0;
        case (w_seg)
            7'h3F: w_code = 4'h0;
            7'h06: w_code = 4'h1;
            7'h5B: w_code = 4'h2;
            7'h4F: w_code = 4'h3;
            7'h66: w_code = 4'h4;
            7'h6D: w_code = 4'h5;
            7'h7D: w_code = 4'h6;
            7'h07: w_code = 4'h7;
            7'h7F: w_code = 4'h8;
            7'h6F: w_code = 4'h9;
            7'h77: w_code = 4'hA;
            7'h7C: w_code = 4'hB;
            7'h39: w_code = 4'hC;
            7'h5E: w_code = 4'hD;
            7'h79: w_code = 4'hE;
            7'h71: w_code = 4'hF;
            7'h00: w_blank = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    // Stability filter: a digit is captured only after a run of identical samples
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= c_ST_WAIT;
            r_run      <= '0;
            r_prev_sel <= 4'd0;
            r_prev_seg <= 7'd0;
            r_prev_dp  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_WAIT: begin
                    if (w_valid) begin
                        r_prev_sel <= w_sel;
                        r_prev_seg <= w_seg;
                        r_prev_dp  <= w_dp;
                        r_run      <= c_RUN_W'(1);
                        r_state    <= (STABLE_CYC <= 1) ? c_ST_HELD : c_ST_COUNT;
                    end
                end
                c_ST_COUNT: begin
                    if (!w_valid) begin
                        r_state <= c_ST_WAIT;
                    end else if (w_same) begin
                        if (w_run_inc >= c_STABLE) begin
                            r_state <= c_ST_HELD;
                        end else begin
                            r_run <= w_run_inc[c_RUN_W-1:0];
                        end
                    end else begin
                        r_prev_sel <= w_sel;
                        r_prev_seg <= w_seg;
                        r_prev_dp  <= w_dp;
                        r_run      <= c_RUN_W'(1);
                    end
                end
                c_ST_HELD: begin
                    if (!w_valid) begin
                        r_state <= c_ST_WAIT;
                    end else if (!w_same) begin
                        r_prev_sel <= w_sel;
                        r_prev_seg <= w_seg;
                        r_prev_dp  <= w_dp;
                        r_run      <= c_RUN_W'(1);
                        r_state    <= c_ST_COUNT;
                    end
                end
                default: r_state <= c_ST_WAIT;
            endcase
        end
    end

    // Shadow frame: last capture per digit wins; seen restarts after a publish
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sh_code  <= 16'd0;
            r_sh_blank <= 4'hF;
            r_sh_dp    <= 4'd0;
            r_sh_err   <= 4'd0;
            r_seen     <= 4'd0;
        end else begin
            if (w_capture) begin
                r_sh_code[{w_idx, 2'b00} +: 4] <= w_code;
                r_sh_blank[w_idx]              <= w_blank;
                r_sh_dp[w_idx]                 <= w_dp;
                r_sh_err[w_idx]                <= w_err;
            end
            r_seen <= (w_publish ? 4'd0 : r_seen) | (w_capture ? w_sel : 4'd0);
        end
    end

    // Publish complete frames and track staleness; a publish overrides timeout
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Digits     <= 16'd0;
            Blank      <= 4'hF;
            DP         <= 4'd0;
            Err        <= 4'd0;
            FrameValid <= 1'b0;
            Stale      <= 1'b0;
            r_to_cnt   <= '0;
        end else if (w_publish) begin
            Digits     <= r_sh_code;
            Blank      <= r_sh_blank;
            DP         <= r_sh_dp;
            Err        <= r_sh_err;
            FrameValid <= 1'b1;
            Stale      <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            FrameValid <= 1'b0;
            if (r_to_cnt != c_TIMEOUT) begin
                r_to_cnt <= w_to_next;
            end
            if (w_to_next == c_TIMEOUT) begin
                Stale <= 1'b1;
            end
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    logic w_ghost;
    assign w_ghost = (r_state == c_ST_COUNT) && !w_valid;

    // Saturating count of bad captures and ghost gaps
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ErrCnt <= 8'd0;
        end else if (((w_capture && w_err) || w_ghost) && (ErrCnt != 8'hFF)) begin
            ErrCnt <= ErrCnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire
